// File: rtl/proj_pkg.sv
// Shared types and constants for the sorter controller slice.
// Holds the controller state enum, default widths and the packing helper.
package proj_pkg;

   localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
   localparam int INDICE_LEN                    = 8;
   localparam int HASHER_SORTER_SIGNATURE       = 16;
   localparam int SORTER_CTRL_COUNT_W           = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_FEED  = 2'd2,
      ST_DONE  = 2'd3
   } sorter_ctrl_state_e;

   // Signature in the upper bits so that a plain compare of packed words
   // orders elements by signature first.
   function automatic logic [HASHER_SORTER_SIGNATURE+INDICE_LEN-1:0] signature_index_pack(
      input logic [HASHER_SORTER_SIGNATURE-1:0] sig,
      input logic [INDICE_LEN-1:0]              idx
   );
      return {sig, idx};
   endfunction

endpackage

// File: rtl/proj_sorter.sv
// Keeps the INDICES_COUNT smallest (signature, index) pairs seen since reset.
// Slot 0 holds the smallest signature. Ties keep the earlier element first.
// Empty slots hold signature all-ones / index 0, so feeding all-ones is a no-op.
module proj_sorter #(
   parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
   parameter int INDICE_LEN    = proj_pkg::INDICE_LEN,
   parameter int SIGNATURE_LEN = proj_pkg::HASHER_SORTER_SIGNATURE
) (
   input  logic                                    i_clk,
   input  logic                                    i_rst_n,
   input  logic [SIGNATURE_LEN-1:0]                i_signature,
   input  logic [INDICE_LEN-1:0]                   i_index,
   output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] o_idx
);

   logic [INDICES_COUNT-1:0][SIGNATURE_LEN-1:0] r_sig;
   logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]    r_idx;
   logic [INDICES_COUNT-1:0][SIGNATURE_LEN-1:0] w_sig_nxt;
   logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]    w_idx_nxt;
   logic [INDICES_COUNT-1:0]                    w_lt;

   // Slots are sorted, so w_lt is a thermometer code: the first set bit is
   // the insertion point, slots after it shift down by one.
   for (genvar g = 0; g < INDICES_COUNT; g++) begin : g_slot
      assign w_lt[g] = (i_signature < r_sig[g]);
      if (g == 0) begin : g_head
         assign w_sig_nxt[g] = w_lt[g] ? i_signature : r_sig[g];
         assign w_idx_nxt[g] = w_lt[g] ? i_index     : r_idx[g];
      end else begin : g_body
         assign w_sig_nxt[g] = !w_lt[g] ? r_sig[g] : (w_lt[g-1] ? r_sig[g-1] : i_signature);
         assign w_idx_nxt[g] = !w_lt[g] ? r_idx[g] : (w_lt[g-1] ? r_idx[g-1] : i_index);
      end
   end

   // Slot storage; reset empties every slot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sig <= '1;
         r_idx <= '0;
      end else begin
         r_sig <= w_sig_nxt;
         r_idx <= w_idx_nxt;
      end
   end

   assign o_idx = r_idx;

endmodule

// File: rtl/proj_sorter_ctrl.sv
// Document sequencer around proj_sorter: clears the sorter, feeds one
// document of elements, then presents the K smallest indices.
// Optional build macro PROJ_SORTER_CTRL_MAXLEN_EN: ends a document after
// MAX_ELEMS elements and flags it on out_truncated.
//
// state | meaning
// IDLE  | waiting for in_start
// CLEAR | sorter held in reset for one cycle, count cleared
// FEED  | accepting elements until in_last (or length limit)
// DONE  | result presented until taken by in_ready
module proj_sorter_ctrl
   import proj_pkg::*;
#(
   parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
   parameter int INDICE_LEN    = proj_pkg::INDICE_LEN,
   parameter int SIGNATURE_LEN = proj_pkg::HASHER_SORTER_SIGNATURE,
   parameter int COUNT_W       = proj_pkg::SORTER_CTRL_COUNT_W,
   parameter int MAX_ELEMS     = 1024
) (
   input  logic                                    in_clk,
   input  logic                                    in_rst_n,
   input  logic                                    in_start,
   input  logic                                    in_valid,
   output logic                                    out_ready,
   input  logic [SIGNATURE_LEN-1:0]                in_signature,
   input  logic [INDICE_LEN-1:0]                   in_index,
   input  logic                                    in_last,
   output logic                                    out_valid,
   input  logic                                    in_ready,
   output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] out_smallest_idx,
   output logic [COUNT_W-1:0]                      out_count,
   output logic                                    out_busy
`ifdef PROJ_SORTER_CTRL_MAXLEN_EN
   ,
   output logic                                    out_truncated
`endif
);

   if (MAX_ELEMS < 1) begin : g_bad_max_elems
      $error("proj_sorter_ctrl: MAX_ELEMS must be at least 1");
   end

   sorter_ctrl_state_e          r_state;
   sorter_ctrl_state_e          w_state_nxt;
   logic                        r_clear_n;
   logic [COUNT_W-1:0]          r_count;
   logic [COUNT_W-1:0]          w_count_inc;
   logic                        w_xfer;
   logic                        w_hit_max;
   logic                        w_sorter_rst_n;
   logic [SIGNATURE_LEN-1:0]    w_feed_sig;
   logic [INDICE_LEN-1:0]       w_feed_idx;

   assign w_xfer      = in_valid & out_ready;
   assign w_count_inc = r_count + 1'b1;

`ifdef PROJ_SORTER_CTRL_MAXLEN_EN
   logic r_truncated;

   assign w_hit_max     = w_xfer & ~in_last & (w_count_inc == COUNT_W'(MAX_ELEMS));
   assign out_truncated = r_truncated;

   // Truncation flag: set by the limit-reaching transfer, cleared per document.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_truncated <= 1'b0;
      end else if (r_state == ST_CLEAR) begin
         r_truncated <= 1'b0;
      end else if (w_hit_max) begin
         r_truncated <= 1'b1;
      end
   end
`else
   assign w_hit_max = 1'b0;
`endif

   // State register.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (in_start) w_state_nxt = ST_CLEAR;
         ST_CLEAR: w_state_nxt = ST_FEED;
         ST_FEED:  if (w_xfer && (in_last || w_hit_max)) w_state_nxt = ST_DONE;
         ST_DONE:  if (in_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake and status outputs, decoded from the state alone.
   always_comb begin
      out_ready = 1'b0;
      out_valid = 1'b0;
      out_busy  = 1'b1;
      case (r_state)
         ST_IDLE: out_busy  = 1'b0;
         ST_FEED: out_ready = 1'b1;
         ST_DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   // Sorter clear strobe: low exactly while the state is CLEAR.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_clear_n <= 1'b1;
      end else begin
         r_clear_n <= (w_state_nxt != ST_CLEAR);
      end
   end

   // Accepted-element counter, saturating, held through DONE.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_count <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_count <= '0;
      end else if (w_xfer && !(&r_count)) begin
         r_count <= w_count_inc;
      end
   end

   assign out_count      = r_count;
   assign w_sorter_rst_n = in_rst_n & r_clear_n;

   // Idle cycles feed the neutral element so the sorter state is untouched.
   assign w_feed_sig = w_xfer ? in_signature : '1;
   assign w_feed_idx = w_xfer ? in_index     : '0;

   proj_sorter #(
      .INDICES_COUNT (INDICES_COUNT),
      .INDICE_LEN    (INDICE_LEN),
      .SIGNATURE_LEN (SIGNATURE_LEN)
   ) u_sorter (
      .i_clk       (in_clk),
      .i_rst_n     (w_sorter_rst_n),
      .i_signature (w_feed_sig),
      .i_index     (w_feed_idx),
      .o_idx       (out_smallest_idx)
   );

endmodule

// File: tb/tb_proj_sorter_ctrl.sv
// Scoreboard bench for proj_sorter_ctrl. Honours PROJ_SORTER_CTRL_MAXLEN_EN.
module tb_proj_sorter_ctrl;
   import proj_pkg::*;

   localparam int K  = 4;
   localparam int IL = 8;
   localparam int SL = 16;
   localparam int CW = 16;
`ifdef PROJ_SORTER_CTRL_MAXLEN_EN
   localparam int MAXE = 3;
`else
   localparam int MAXE = 1024;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_start = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_last = 1'b0;
   logic                  in_ready = 1'b1;
   logic [SL-1:0]         in_sig = '0;
   logic [IL-1:0]         in_idx = '0;
   logic                  out_ready, out_valid, out_busy;
   logic [K-1:0][IL-1:0]  res;
   logic [CW-1:0]         cnt;
   logic                  trunc;

   proj_sorter_ctrl #(
      .INDICES_COUNT (K), .INDICE_LEN (IL), .SIGNATURE_LEN (SL),
      .COUNT_W (CW), .MAX_ELEMS (MAXE)
   ) dut (
      .in_clk (clk), .in_rst_n (rst_n), .in_start (in_start),
      .in_valid (in_valid), .out_ready (out_ready),
      .in_signature (in_sig), .in_index (in_idx), .in_last (in_last),
      .out_valid (out_valid), .in_ready (in_ready),
      .out_smallest_idx (res), .out_count (cnt), .out_busy (out_busy)
`ifdef PROJ_SORTER_CTRL_MAXLEN_EN
      , .out_truncated (trunc)
`endif
   );

`ifndef PROJ_SORTER_CTRL_MAXLEN_EN
   assign trunc = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [K-1:0][IL-1:0] idx;
      int                   count;
      bit                   trunc;
   } exp_t;

   exp_t sb[$];
   int   d_sig[$];
   int   d_idx[$];
   int   errors = 0;
   int   checks = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference: a document is the prefix up to in_last or the length limit;
   // the result is the K lowest signatures, earliest first on ties.
   function automatic void model(input bit with_last, output exp_t e, output int n_acc);
      int ps[$];
      int pi[$];
      int m;
      n_acc   = 0;
      e.trunc = 1'b0;
      e.idx   = '0;
      for (int i = 0; i < d_sig.size(); i++) begin
         ps.push_back(d_sig[i]);
         pi.push_back(d_idx[i]);
         n_acc++;
         if (with_last && i == d_sig.size() - 1) break;
         if (n_acc == MAXE) begin
            e.trunc = 1'b1;
            break;
         end
      end
      e.count = n_acc;
      for (int s = 0; s < K; s++) begin
         if (ps.size() == 0) break;
         m = 0;
         for (int j = 1; j < ps.size(); j++) if (ps[j] < ps[m]) m = j;
         e.idx[s] = IL'(pi[m]);
         ps.delete(m);
         pi.delete(m);
      end
   endfunction

   // Monitor: every result the DUT hands over is checked against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && in_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got idx 0x%0h count %0d with nothing expected", res, cnt);
         end else begin
            e = sb.pop_front();
            chk("result_idx", 64'(res), 64'(e.idx));
            chk("result_count", 64'(cnt), 64'(e.count));
            chk("result_trunc", 64'(trunc), 64'(e.trunc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while (out_busy && n < 300) begin
         tick();
         n++;
      end
      if (out_busy) chk({name, "_timeout"}, 64'(out_busy), 64'd0);
   endtask

   task automatic wait_valid(string name);
      int n = 0;
      while (!out_valid && n < 300) begin
         tick();
         n++;
      end
      if (!out_valid) chk({name, "_timeout"}, 64'(out_valid), 64'd1);
   endtask

   task automatic pulse_start();
      in_start = 1'b1;
      tick();
      in_start = 1'b0;
   endtask

   task automatic send(input int s, input int i, input bit last);
      int n = 0;
      in_sig   = SL'(s);
      in_idx   = IL'(i);
      in_last  = last;
      in_valid = 1'b1;
      while (!out_ready && n < 100) begin
         tick();
         n++;
      end
      if (!out_ready) chk("send_ready_timeout", 64'(out_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_sig   = SL'($urandom);
      in_idx   = IL'($urandom);
   endtask

   task automatic issue_doc(input bit with_last, input int blo, input int bhi, input bit push);
      exp_t e;
      int   n_acc;
      model(with_last, e, n_acc);
      if (push) sb.push_back(e);
      pulse_start();
      for (int k = 0; k < n_acc; k++) begin
         send(d_sig[k], d_idx[k], with_last && (k == d_sig.size() - 1));
         if (k < n_acc - 1) repeat ($urandom_range(bhi, blo)) tick();
      end
   endtask

   task automatic check_reset_outputs(string name);
      chk({name, "_busy"}, 64'(out_busy), 64'd0);
      chk({name, "_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_ready"}, 64'(out_ready), 64'd0);
      chk({name, "_count"}, 64'(cnt), 64'd0);
      chk({name, "_idx"}, 64'(res), 64'd0);
      chk({name, "_trunc"}, 64'(trunc), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int sig_max;
      repeat (2) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      d_sig = '{9, 3, 7, 1, 5};  d_idx = '{10, 11, 12, 13, 14};
      issue_doc(1'b1, 0, 0, 1'b1);
      wait_idle("doc_basic");

      d_sig = '{4};  d_idx = '{7};
      issue_doc(1'b1, 0, 0, 1'b1);
      wait_idle("doc_single");

      d_sig = '{9, 3, 7, 1, 5};  d_idx = '{10, 11, 12, 13, 14};
      issue_doc(1'b1, 3, 3, 1'b1);
      wait_idle("doc_bubbles");

      d_sig = '{2, 8};  d_idx = '{20, 21};
      issue_doc(1'b1, 0, 0, 1'b1);
      wait_idle("doc_b2b");

      // Result held while the consumer stalls; in_start there is ignored.
      in_ready = 1'b0;
      d_sig = '{6, 2, 9};  d_idx = '{30, 31, 32};
      issue_doc(1'b1, 0, 1, 1'b1);
      wait_valid("hold");
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_idx", 64'(res), 64'(sb[0].idx));
      end
      pulse_start();
      chk("hold_start_ignored_valid", 64'(out_valid), 64'd1);
      chk("hold_start_ignored_idx", 64'(res), 64'(sb[0].idx));
      in_ready = 1'b1;
      wait_idle("hold");
      repeat (2) tick();
      chk("hold_start_ignored_busy", 64'(out_busy), 64'd0);

      for (int d = 0; d < 20; d++) begin
         d_sig.delete();
         d_idx.delete();
         len     = $urandom_range(8, 1);
         sig_max = (d % 2 == 0) ? 7 : 16'hFFFE;
         for (int k = 0; k < len; k++) begin
            d_sig.push_back($urandom_range(sig_max, 0));
            d_idx.push_back($urandom_range(255, 0));
         end
         issue_doc(1'b1, 0, 2, 1'b1);
         wait_idle("doc_random");
      end

`ifdef PROJ_SORTER_CTRL_MAXLEN_EN
      in_ready = 1'b0;
      d_sig = '{40, 10, 30, 5, 1};  d_idx = '{50, 51, 52, 53, 54};
      issue_doc(1'b0, 0, 0, 1'b1);
      chk("trunc_valid", 64'(out_valid), 64'd1);
      chk("trunc_ready", 64'(out_ready), 64'd0);
      chk("trunc_count", 64'(cnt), 64'd3);
      chk("trunc_flag", 64'(trunc), 64'd1);
      in_valid = 1'b1;
      in_sig   = 16'd0;
      in_idx   = 8'd99;
      repeat (2) tick();
      in_valid = 1'b0;
      chk("trunc_extra_count", 64'(cnt), 64'd3);
      chk("trunc_extra_idx", 64'(res), 64'(sb[0].idx));
      in_ready = 1'b1;
      wait_idle("trunc");
`endif

      // Reset mid-FEED: document aborted, nothing emitted.
      pulse_start();
      send(5, 60, 1'b0);
      send(6, 61, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_feed");
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_feed_after_busy", 64'(out_busy), 64'd0);
      chk("rst_feed_after_idx", 64'(res), 64'd0);

      // Reset mid-DONE: the pending result is dropped.
      in_ready = 1'b0;
      d_sig = '{3, 1};  d_idx = '{70, 71};
      issue_doc(1'b1, 0, 0, 1'b0);
      wait_valid("rst_done");
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_done");
      in_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_done_after_valid", 64'(out_valid), 64'd0);
      chk("rst_done_after_busy", 64'(out_busy), 64'd0);

      d_sig = '{12, 11};  d_idx = '{80, 81};
      issue_doc(1'b1, 0, 0, 1'b1);
      wait_idle("doc_post_reset");

      repeat (4) tick();
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
